// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM pipeline register, data-memory access FSM and write-back register
module mem_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   EX_valid,
    input  logic [31:0]            EX_pc,
    input  logic [31:0]            EX_pc_plus4,
    input  logic [31:0]            EX_ALUresult,
    input  logic [31:0]            EX_store_data,
    input  logic [4:0]             EX_Rw,
    input  logic                   EX_RegWrite,
    input  logic                   EX_MemtoReg,
    input  logic                   EX_Memwrite,
    input  logic                   EX_lb,
    input  logic                   EX_lbu,
    input  logic                   EX_sb,
    input  logic                   EX_jal,
    output logic                   mem_stall,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [31:0]            dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_be,
    input  logic [31:0]            dmem_rdata,
    input  logic                   dmem_ready,
    output logic                   WB_valid,
    output logic                   WB_RegWrite,
    output logic [4:0]             WB_Rw,
    output logic [31:0]            WB_data,
    output logic                   align_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_ALU, S_ACC} state_t;

    state_t      state;
    logic [31:0] m_pc_plus4;
    logic [31:0] m_alu;
    logic [31:0] m_store;
    logic [4:0]  m_rw;
    logic        m_regwrite;
    logic        m_memtoreg;
    logic        m_memwrite;
    logic        m_lb;
    logic        m_lbu;
    logic        m_sb;
    logic        m_jal;

    logic        ex_mem_op;
    logic        ex_word_op;
    logic        ex_misaligned;
    logic [1:0]  lane;
    logic [7:0]  rbyte;
    logic [31:0] load_data;
    logic [31:0] wb_next_data;
    logic        m_valid;

    // The instruction PC travels with the bundle for debug only; nothing downstream consumes it.
    logic        unused_pc;
    assign unused_pc = ^EX_pc;

    assign ex_mem_op     = EX_MemtoReg | EX_Memwrite;
    assign ex_word_op    = ex_mem_op & ~(EX_lb | EX_lbu | EX_sb);
    assign ex_misaligned = ex_word_op & (EX_ALUresult[1:0] != 2'b00);

    assign m_valid   = (state != S_IDLE);
    assign lane      = m_alu[1:0];
    assign dmem_req  = (state == S_ACC);
    assign dmem_we   = (state == S_ACC) & m_memwrite;
    assign mem_stall = (state == S_ACC) & ~dmem_ready;
    assign dmem_addr = {m_alu[31:2], 2'b00};
    assign dmem_be   = m_sb ? (4'b0001 << lane) : 4'b1111;
    assign dmem_wdata = m_sb ? {4{m_store[7:0]}} : m_store;

    // Pick the addressed byte lane out of the little-endian read word and extend it.
    always_comb begin
        rbyte = dmem_rdata[7:0];
        case (lane)
            2'd0: rbyte = dmem_rdata[7:0];
            2'd1: rbyte = dmem_rdata[15:8];
            2'd2: rbyte = dmem_rdata[23:16];
            2'd3: rbyte = dmem_rdata[31:24];
            default: rbyte = dmem_rdata[7:0];
        endcase
        if (m_lb)
            load_data = {{24{rbyte[7]}}, rbyte};
        else if (m_lbu)
            load_data = {24'h000000, rbyte};
        else
            load_data = dmem_rdata;
        if (m_memtoreg)
            wb_next_data = load_data;
        else if (m_jal)
            wb_next_data = m_pc_plus4;
        else
            wb_next_data = m_alu;
    end

    // EX/MEM register and access FSM; a misaligned word op is demoted to a harmless ALU slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            m_pc_plus4 <= 32'h0;
            m_alu      <= 32'h0;
            m_store    <= 32'h0;
            m_rw       <= 5'd0;
            m_regwrite <= 1'b0;
            m_memtoreg <= 1'b0;
            m_memwrite <= 1'b0;
            m_lb       <= 1'b0;
            m_lbu      <= 1'b0;
            m_sb       <= 1'b0;
            m_jal      <= 1'b0;
            align_err  <= 1'b0;
        end else if (!mem_stall) begin
            m_pc_plus4 <= EX_pc_plus4;
            m_alu      <= EX_ALUresult;
            m_store    <= EX_store_data;
            m_rw       <= EX_Rw;
            m_regwrite <= EX_RegWrite & ~ex_misaligned;
            m_memtoreg <= EX_MemtoReg;
            m_memwrite <= EX_Memwrite & ~ex_misaligned;
            m_lb       <= EX_lb;
            m_lbu      <= EX_lbu;
            m_sb       <= EX_sb;
            m_jal      <= EX_jal;
            if (!EX_valid)
                state <= S_IDLE;
            else if (ex_mem_op && !ex_misaligned)
                state <= S_ACC;
            else
                state <= S_ALU;
            if (EX_valid && ex_misaligned)
                align_err <= 1'b1;
        end
    end

    // Write-back register: a bubble while the access is outstanding, otherwise the finished M slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_valid    <= 1'b0;
            WB_RegWrite <= 1'b0;
            WB_Rw       <= 5'd0;
            WB_data     <= 32'h0;
        end else if (mem_stall) begin
            WB_valid    <= 1'b0;
            WB_RegWrite <= 1'b0;
        end else begin
            WB_valid    <= m_valid;
            WB_RegWrite <= m_valid & m_regwrite & (m_rw != 5'd0);
            WB_Rw       <= m_rw;
            WB_data     <= wb_next_data;
        end
    end

    // Saturating count of cycles spent stalled on memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (mem_stall && (stall_cycles != {STALL_CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a latency-programmable memory model
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EX_valid = 1'b0;
    logic [31:0] EX_pc = 32'h0, EX_pc_plus4 = 32'h0, EX_ALUresult = 32'h0, EX_store_data = 32'h0;
    logic [4:0]  EX_Rw = 5'd0;
    logic        EX_RegWrite = 1'b0, EX_MemtoReg = 1'b0, EX_Memwrite = 1'b0;
    logic        EX_lb = 1'b0, EX_lbu = 1'b0, EX_sb = 1'b0, EX_jal = 1'b0;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ready = 1'b0;
    logic        WB_valid, WB_RegWrite;
    logic [4:0]  WB_Rw;
    logic [31:0] WB_data;
    logic        align_err;
    logic [15:0] stall_cycles;

    mem_stage #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_pc_plus4(EX_pc_plus4),
        .EX_ALUresult(EX_ALUresult), .EX_store_data(EX_store_data), .EX_Rw(EX_Rw),
        .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_Memwrite(EX_Memwrite),
        .EX_lb(EX_lb), .EX_lbu(EX_lbu), .EX_sb(EX_sb), .EX_jal(EX_jal),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite), .WB_Rw(WB_Rw), .WB_data(WB_data),
        .align_err(align_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rw;
        logic        regwrite;
        logic [31:0] data;
        bit          chk_data;
        int          cyc;
    } wb_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    wb_t  wb_q[$];
    mem_t mem_q[$];
    int   vec = 0;
    int   err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vec++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Monitor: every valid WB slot must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wb_t e;
        if (!rst && WB_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                vec++;
                err++;
                $display("FAIL wb_unexpected: got WB_valid=1 Rw=%0d, expected no write-back", WB_Rw);
            end else begin
                e = wb_q.pop_front();
                chk("wb_rw", {27'h0, WB_Rw}, {27'h0, e.rw});
                chk("wb_regwrite", {31'h0, WB_RegWrite}, {31'h0, e.regwrite});
                if (e.chk_data)
                    chk("wb_data", WB_data, e.data);
                chk("wb_cycle", cyc, e.cyc);
            end
        end
    end

    // Memory model: serves each request after its programmed latency and checks the request fields.
    mem_t cur;
    bit   have = 0;
    int   cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            have = 0;
            dmem_ready = 1'b0;
        end else begin
            if (dmem_ready) have = 0;
            dmem_ready = 1'b0;
            dmem_rdata = 32'h0;
            if (dmem_req === 1'b1) begin
                if (!have) begin
                    if (mem_q.size() == 0) begin
                        vec++;
                        err++;
                        $display("FAIL dmem_unexpected: got dmem_req=1 addr=%h, expected no request", dmem_addr);
                    end else begin
                        cur = mem_q.pop_front();
                        have = 1;
                        cnt = 0;
                    end
                end
                if (have) begin
                    chk("dmem_addr", dmem_addr, cur.addr);
                    chk("dmem_we", {31'h0, dmem_we}, {31'h0, cur.we});
                    chk("dmem_be", {28'h0, dmem_be}, {28'h0, cur.be});
                    if (cur.we)
                        chk("dmem_wdata", dmem_wdata, cur.wdata);
                    cnt++;
                    if (cnt >= cur.lat) begin
                        dmem_ready = 1'b1;
                        dmem_rdata = cur.rdata;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] alu, input logic [31:0] st, input logic [31:0] pc4,
                         input logic [4:0] rw, input logic regw, input logic m2r, input logic mw,
                         input logic lb, input logic lbu, input logic sb, input logic jal,
                         input int lat, input logic [31:0] rdata, input logic [31:0] exp_data,
                         input bit chk_data, input bit want_wb);
        bit   memop, mis;
        int   n;
        wb_t  w;
        mem_t m;
        memop = m2r | mw;
        mis   = memop & !(lb | lbu | sb) & (alu[1:0] != 2'b00);
        @(negedge clk);
        EX_valid = 1'b1; EX_pc = pc4 - 32'd4; EX_pc_plus4 = pc4; EX_ALUresult = alu;
        EX_store_data = st; EX_Rw = rw; EX_RegWrite = regw; EX_MemtoReg = m2r;
        EX_Memwrite = mw; EX_lb = lb; EX_lbu = lbu; EX_sb = sb; EX_jal = jal;
        #2;
        n = 0;
        while (mem_stall && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            vec++;
            err++;
            $display("FAIL issue_timeout: got mem_stall stuck for %0d cycles, expected release", n);
        end
        if (memop && !mis) begin
            m.lat = lat; m.rdata = rdata; m.addr = {alu[31:2], 2'b00}; m.we = mw;
            m.be = sb ? (4'b0001 << alu[1:0]) : 4'b1111;
            m.wdata = sb ? {4{st[7:0]}} : st;
            mem_q.push_back(m);
        end
        if (want_wb) begin
            w.rw = rw;
            w.regwrite = regw & !mis & (rw != 5'd0);
            w.data = exp_data;
            w.chk_data = chk_data;
            w.cyc = cyc + 1 + ((memop && !mis) ? lat : 1);
            wb_q.push_back(w);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        EX_valid = 1'b0; EX_RegWrite = 1'b0; EX_MemtoReg = 1'b0; EX_Memwrite = 1'b0;
        EX_lb = 1'b0; EX_lbu = 1'b0; EX_sb = 1'b0; EX_jal = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wb_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (wb_q.size() != 0) begin
            vec++;
            err++;
            $display("FAIL drain_timeout: got %0d pending write-backs, expected 0", wb_q.size());
        end
        @(negedge clk);
        #3;
    endtask

    initial begin
        #2;
        chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_wb_valid", {31'h0, WB_valid}, 32'h0);
        chk("rst_wb_data", WB_data, 32'h0);
        chk("rst_align_err", {31'h0, align_err}, 32'h0);
        chk("rst_stall_cycles", {16'h0, stall_cycles}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;

        // addu r8
        issue(32'h12345678, 32'h0, 32'h00400004, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h12345678, 1, 1);
        idle();
        drain();
        chk("addu_no_stall", {16'h0, stall_cycles}, 32'd0);

        // sb to 0x1003, ready on third ACC cycle
        issue(32'h00001003, 32'h000000AB, 32'h00400008, 5'd0, 0, 0, 1, 0, 0, 1, 0, 3, 32'h0, 32'h00001003, 1, 1);
        idle();
        drain();
        chk("sb_stall_cycles", {16'h0, stall_cycles}, 32'd2);

        // lb then lbu back to back from 0x2001
        issue(32'h00002001, 32'h0, 32'h0040000C, 5'd9, 1, 1, 0, 1, 0, 0, 0, 1, 32'h0000F000, 32'hFFFFFFF0, 1, 1);
        issue(32'h00002001, 32'h0, 32'h00400010, 5'd10, 1, 1, 0, 0, 1, 0, 0, 1, 32'h0000F000, 32'h000000F0, 1, 1);
        idle();
        drain();

        // misaligned lw, then aligned lw and sw back to back
        issue(32'h00003002, 32'h0, 32'h00400014, 5'd11, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 1);
        idle();
        drain();
        chk("misaligned_align_err", {31'h0, align_err}, 32'h1);
        issue(32'h00003004, 32'h0, 32'h00400018, 5'd12, 1, 1, 0, 0, 0, 0, 0, 2, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1);
        issue(32'h00004000, 32'h11223344, 32'h0040001C, 5'd0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h00004000, 1, 1);
        idle();
        drain();
        chk("lw_sw_stall_cycles", {16'h0, stall_cycles}, 32'd3);

        // jal r31, then a write to r0
        issue(32'h00000000, 32'h0, 32'h00400008, 5'd31, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h00400008, 1, 1);
        issue(32'h00000055, 32'h0, 32'h00400024, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h00000055, 1, 1);
        idle();
        drain();
        chk("align_err_sticky", {31'h0, align_err}, 32'h1);

        // lw that never completes, abandoned by reset
        issue(32'h00005000, 32'h0, 32'h00400028, 5'd13, 1, 1, 0, 0, 0, 0, 0, 100, 32'h0, 32'h0, 0, 0);
        idle();
        @(negedge clk);
        chk("pre_rst_dmem_req", {31'h0, dmem_req}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("midacc_rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("midacc_rst_mem_stall", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_wb_valid", {31'h0, WB_valid}, 32'h0);
        chk("post_rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("post_rst_align_err", {31'h0, align_err}, 32'h0);
        chk("post_rst_stall_cycles", {16'h0, stall_cycles}, 32'd0);
        chk("post_rst_pending", wb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1);
    end

endmodule
